// File: rtl/link_credit_sync.sv
// Credit-based flow control for one virtual channel: gates sends on remote credits,
// tracks locally freed buffer slots as owed credits. Optional checks: LINK_CREDIT_SYNC_ASSERT_EN.
module link_credit_sync #(
  parameter int unsigned NumCredits      = 8,
  parameter int unsigned ForceSendThresh = NumCredits - 4,
  parameter bit          CredOnlyPktMode = 1'b1,
  parameter type         credit_t        = logic [$clog2(NumCredits+1)-1:0],
  parameter type         data_t          = logic [31:0]
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  data_t   data_to_send_i,
  output data_t   data_to_send_o,
  input  logic    send_valid_i,
  output logic    send_ready_o,
  output logic    send_valid_o,
  input  logic    send_ready_i,
  output credit_t credits_to_send_o,
  output logic    credits_only_packet_o,
  input  logic    req_cred_to_buffer_msg,
  input  credit_t credits_received_i,
  input  logic    receive_cred_i,
  input  logic    buffer_queue_out_val_i,
  input  logic    buffer_queue_out_rdy_i,
  input  logic    allow_cred_consume_i,
  input  logic    consume_cred_to_send_i
);

  localparam int unsigned CW = $bits(credit_t);
  localparam logic [CW:0] MaxCred = (CW+1)'(NumCredits);
  localparam logic [CW:0] Thresh  = (CW+1)'(ForceSendThresh);

  logic [CW-1:0] avail_q, owed_q;
  logic [CW:0]   avail_sum, avail_nxt;
  logic [CW-1:0] owed_nxt;
  logic          has_cred, data_beat, force_cop, data_hs, dequeue;

  // Data beats bypass the credit check when the message class needs no buffer credit.
  assign has_cred  = (avail_q != '0) | ~req_cred_to_buffer_msg;
  assign data_beat = send_valid_i & has_cred;
  assign force_cop = CredOnlyPktMode & allow_cred_consume_i
                   & ({1'b0, owed_q} >= Thresh) & ~data_beat;

  assign data_to_send_o        = data_to_send_i;
  assign send_valid_o          = ~rst_i & (data_beat | force_cop);
  assign credits_only_packet_o = ~rst_i & force_cop;
  assign send_ready_o          = send_ready_i & has_cred & ~force_cop;
  assign credits_to_send_o     = credit_t'(owed_q);

  assign data_hs = data_beat & send_ready_i & req_cred_to_buffer_msg;
  assign dequeue = buffer_queue_out_val_i & buffer_queue_out_rdy_i;

  // data_hs implies avail_q != 0, so the subtraction never wraps.
  always_comb begin
    avail_sum = {1'b0, avail_q};
    if (receive_cred_i) avail_sum = avail_sum + {1'b0, credits_received_i};
    avail_nxt = avail_sum - (CW+1)'(data_hs);
    if (avail_nxt > MaxCred) avail_nxt = MaxCred;
  end

  always_comb begin
    owed_nxt = owed_q;
    if (consume_cred_to_send_i)
      owed_nxt = CW'(dequeue);
    else if (dequeue && ({1'b0, owed_q} < MaxCred))
      owed_nxt = owed_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      avail_q <= MaxCred[CW-1:0];
      owed_q  <= '0;
    end else begin
      avail_q <= avail_nxt[CW-1:0];
      owed_q  <= owed_nxt;
    end
  end

`ifdef LINK_CREDIT_SYNC_ASSERT_EN
  if (ForceSendThresh > NumCredits) begin : g_bad_thresh
    $error("link_credit_sync: ForceSendThresh exceeds NumCredits");
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (receive_cred_i)
        assert (({1'b0, avail_q} + {1'b0, credits_received_i}) <= MaxCred)
          else $error("link_credit_sync: credit return overflows remote buffer depth");
      assert ({1'b0, owed_q} <= MaxCred)
        else $error("link_credit_sync: owed credit count above buffer depth");
      assert (!(data_hs && (avail_q == '0) && req_cred_to_buffer_msg))
        else $error("link_credit_sync: data sent with no credit available");
    end
  end
`else
  // Checks compiled out; behaviour is identical.
`endif

endmodule

// File: tb/tb_link_credit_sync.sv
// Randomized and directed bench for link_credit_sync against a counter-level model.
module tb_link_credit_sync;
  localparam int N  = 8;
  localparam int TH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_to_send_i, data_to_send_o;
  logic        send_valid_i, send_ready_o, send_valid_o, send_ready_i;
  logic [3:0]  credits_to_send_o, credits_received_i;
  logic        credits_only_packet_o, req_cred_to_buffer_msg, receive_cred_i;
  logic        buffer_queue_out_val_i, buffer_queue_out_rdy_i;
  logic        allow_cred_consume_i, consume_cred_to_send_i;

  int vecs = 0, errs = 0;
  int m_avail = N, m_owed = 0;
  logic [6:0] obs;

  always #5 clk_i = ~clk_i;

  link_credit_sync dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .data_to_send_i(data_to_send_i), .data_to_send_o(data_to_send_o),
    .send_valid_i(send_valid_i), .send_ready_o(send_ready_o),
    .send_valid_o(send_valid_o), .send_ready_i(send_ready_i),
    .credits_to_send_o(credits_to_send_o), .credits_only_packet_o(credits_only_packet_o),
    .req_cred_to_buffer_msg(req_cred_to_buffer_msg),
    .credits_received_i(credits_received_i), .receive_cred_i(receive_cred_i),
    .buffer_queue_out_val_i(buffer_queue_out_val_i), .buffer_queue_out_rdy_i(buffer_queue_out_rdy_i),
    .allow_cred_consume_i(allow_cred_consume_i), .consume_cred_to_send_i(consume_cred_to_send_i)
  );

  assign obs = {send_valid_o, send_ready_o, credits_only_packet_o, credits_to_send_o};

  // Expected {valid, ready, credits_only, credits_to_send} from the model counters.
  function automatic logic [6:0] exp_vec();
    bit has, dv, frc;
    has = (m_avail != 0) || !req_cred_to_buffer_msg;
    dv  = send_valid_i && has;
    frc = allow_cred_consume_i && (m_owed >= TH) && !dv;
    return {!rst_i && (dv || frc), send_ready_i && has && !frc, !rst_i && frc, 4'(m_owed)};
  endfunction

  task automatic edge_step();
    bit has, hs, deq;
    @(posedge clk_i);
    if (rst_i) begin
      m_avail = N; m_owed = 0;
    end else begin
      has = (m_avail != 0) || !req_cred_to_buffer_msg;
      hs  = send_valid_i && has && send_ready_i && req_cred_to_buffer_msg;
      deq = buffer_queue_out_val_i && buffer_queue_out_rdy_i;
      m_avail = m_avail + (receive_cred_i ? int'(credits_received_i) : 0) - int'(hs);
      if (m_avail > N) m_avail = N;
      if (consume_cred_to_send_i) m_owed = int'(deq);
      else if (deq && m_owed < N) m_owed = m_owed + 1;
    end
    #1;
  endtask

  task automatic idle();
    rst_i = 0; send_valid_i = 0; send_ready_i = 0; req_cred_to_buffer_msg = 1;
    receive_cred_i = 0; credits_received_i = 0; buffer_queue_out_val_i = 0;
    buffer_queue_out_rdy_i = 0; allow_cred_consume_i = 0; consume_cred_to_send_i = 0;
    data_to_send_i = $urandom;
  endtask

  task automatic do_reset();
    idle(); rst_i = 1; edge_step(); rst_i = 0;
  endtask

  task automatic test_reset();
    idle(); rst_i = 1; send_valid_i = 1; send_ready_i = 1;
    edge_step(); edge_step();
    #2; vecs++;
    if (obs !== exp_vec()) begin errs++; $display("FAIL reset_hold: got %b expected %b", obs, exp_vec()); end
    idle(); #1; vecs++;
    if (obs !== 7'b0) begin errs++; $display("FAIL reset_idle: got %b expected %b", obs, 7'b0); end
    edge_step();
  endtask

  task automatic test_burst();
    int beats = 0;
    idle(); send_valid_i = 1; send_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      data_to_send_i = $urandom;
      #2; vecs++;
      if (obs !== exp_vec() || data_to_send_o !== data_to_send_i) begin
        errs++; $display("FAIL burst c%0d: got %b/%h expected %b/%h", i, obs, data_to_send_o, exp_vec(), data_to_send_i);
      end
      if (send_valid_o && send_ready_i && !credits_only_packet_o) beats++;
      edge_step();
    end
    #2; vecs++;
    if (beats != 8 || send_ready_o !== 1'b0) begin
      errs++; $display("FAIL burst_count: got %0d beats ready=%b expected 8 beats ready=0", beats, send_ready_o);
    end
    edge_step(); idle();
  endtask

  task automatic test_credit_return();
    int beats = 0;
    idle(); receive_cred_i = 1; credits_received_i = 4'd3;
    #2; vecs++;
    if (obs !== exp_vec()) begin errs++; $display("FAIL cred_pulse: got %b expected %b", obs, exp_vec()); end
    edge_step(); idle(); send_valid_i = 1; send_ready_i = 1;
    for (int i = 0; i < 6; i++) begin
      #2; vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL cred_ret c%0d: got %b expected %b", i, obs, exp_vec()); end
      if (i == 0 && send_ready_o !== 1'b1) begin
        errs++; $display("FAIL cred_next_cycle: got ready=%b expected 1", send_ready_o);
      end
      if (send_valid_o && send_ready_i && !credits_only_packet_o) beats++;
      edge_step();
    end
    vecs++;
    if (beats != 3) begin errs++; $display("FAIL cred_ret_count: got %0d expected 3", beats); end
    idle();
  endtask

  task automatic test_force();
    idle(); allow_cred_consume_i = 1; buffer_queue_out_val_i = 1; buffer_queue_out_rdy_i = 1;
    for (int i = 0; i < 4; i++) begin
      #2; vecs++;
      if (obs !== exp_vec()) begin errs++; $display("FAIL force_deq c%0d: got %b expected %b", i, obs, exp_vec()); end
      edge_step();
    end
    buffer_queue_out_val_i = 0;
    #2; vecs++;
    if (obs !== {3'b101, 4'd4}) begin errs++; $display("FAIL force_pkt: got %b expected %b", obs, {3'b101, 4'd4}); end
    consume_cred_to_send_i = 1; edge_step(); consume_cred_to_send_i = 0;
    #2; vecs++;
    if (send_valid_o !== 1'b0 || credits_to_send_o !== 4'd0) begin
      errs++; $display("FAIL force_consume: got v=%b c=%0d expected v=0 c=0", send_valid_o, credits_to_send_o);
    end
    edge_step(); idle();
  endtask

  task automatic test_simultaneous();
    int beats = 0;
    idle(); buffer_queue_out_val_i = 1; buffer_queue_out_rdy_i = 1;
    edge_step(); edge_step();
    consume_cred_to_send_i = 1; edge_step(); idle();
    #2; vecs++;
    if (credits_to_send_o !== 4'd1 || obs !== exp_vec()) begin
      errs++; $display("FAIL deq_consume: got %0d expected 1", credits_to_send_o);
    end
    do_reset(); send_valid_i = 1; send_ready_i = 1;
    repeat (3) edge_step();
    receive_cred_i = 1; credits_received_i = 4'd2;
    #2; vecs++;
    if (obs !== exp_vec()) begin errs++; $display("FAIL hs_plus_cred: got %b expected %b", obs, exp_vec()); end
    edge_step(); receive_cred_i = 0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (send_valid_o && send_ready_i && !credits_only_packet_o) beats++;
      edge_step();
    end
    vecs++;
    if (beats != 6) begin errs++; $display("FAIL net_avail: got %0d beats expected 6", beats); end
    idle();
  endtask

  task automatic test_priority();
    do_reset(); allow_cred_consume_i = 1; buffer_queue_out_val_i = 1; buffer_queue_out_rdy_i = 1;
    repeat (4) edge_step();
    buffer_queue_out_val_i = 0; send_valid_i = 1; send_ready_i = 1;
    #2; vecs++;
    if (obs !== {3'b110, 4'd4}) begin errs++; $display("FAIL priority: got %b expected %b", obs, {3'b110, 4'd4}); end
    edge_step(); idle();
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    do_reset(); send_valid_i = 1; send_ready_i = 1;
    buffer_queue_out_val_i = 1; buffer_queue_out_rdy_i = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) buffer_queue_out_val_i = 0;
      edge_step();
    end
    #2; vecs++;
    if (obs !== exp_vec() || credits_to_send_o !== 4'd3) begin
      errs++; $display("FAIL pre_reset: got %b expected %b", obs, exp_vec());
    end
    rst_i = 1; edge_step(); idle();
    #2; vecs++;
    if (obs !== 7'b0) begin errs++; $display("FAIL reset_mid: got %b expected %b", obs, 7'b0); end
    send_valid_i = 1; send_ready_i = 1;
    for (int i = 0; i < 9; i++) begin
      #2;
      if (send_valid_o && send_ready_i && !credits_only_packet_o) beats++;
      edge_step();
    end
    vecs++;
    if (beats != 8) begin errs++; $display("FAIL reset_refill: got %0d beats expected 8", beats); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      send_valid_i           = $urandom_range(0, 2) != 0;
      send_ready_i           = $urandom_range(0, 3) != 0;
      req_cred_to_buffer_msg = $urandom_range(0, 7) != 0;
      allow_cred_consume_i   = $urandom_range(0, 1) != 0;
      buffer_queue_out_val_i = $urandom_range(0, 1) != 0;
      buffer_queue_out_rdy_i = $urandom_range(0, 3) != 0;
      consume_cred_to_send_i = $urandom_range(0, 7) == 0;
      receive_cred_i         = $urandom_range(0, 3) == 0;
      credits_received_i     = receive_cred_i ? 4'($urandom_range(0, N - m_avail)) : 4'($urandom);
      data_to_send_i         = $urandom;
      #2; vecs++;
      if (obs !== exp_vec() || data_to_send_o !== data_to_send_i) begin
        errs++; $display("FAIL random c%0d: got %b expected %b (avail %0d owed %0d)", i, obs, exp_vec(), m_avail, m_owed);
      end
      edge_step();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    test_reset();
    test_burst();
    test_credit_return();
    test_force();
    test_simultaneous();
    test_priority();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
